program_loader: RTL and testbench

Hardware counterpart to the bench-side program load. It clears instruction memory, accepts a program image over a valid/ready word stream, and writes it into instruction memory and data memory word 0x00. It then releases the pipelined CPU from reset, asserts `start`, and runs it for a fixed number of cycles before freezing it. The block sits between the host link and the `CPU` top's `clk_i`/`rst_i`/`start_i` pins and memory write ports.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/program_loader.sv | 186 ++++++++++++++++++
 tb/tb_program_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg : shared state encoding, defaults and header layout for   |
// |              program_loader.                        Rev 1.0          |
// +----------------------------------------------------------------------+
package loader_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_HDR   = 3'd1,
    S_INSTR = 3'd2,
    S_DATA  = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int c_imem_depth = 256;
  localparam int c_run_cycles = 30;

  // Program length lives in the low half of the header word.
  localparam int c_hdr_n_lsb = 0;
  localparam int c_hdr_n_w   = 16;

  function automatic logic [c_hdr_n_w-1:0] hdr_len(input logic [31:0] word);
    return word[c_hdr_n_lsb +: c_hdr_n_w];
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader : clears imem, streams a program image in, then runs  |
// |                  the CPU for a fixed cycle budget.   Rev 1.0         |
// +----------------------------------------------------------------------+
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = c_imem_depth,
  parameter int IMEM_AW    = 8,
  parameter int RUN_CYCLES = c_run_cycles,
  parameter int CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [31:0]        s_data_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  output logic               dmem_we_o,
  output logic [31:0]        dmem_wdata_o,
  output logic               cpu_rst_o,
  output logic               cpu_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   cycle_o
);

  localparam int                     c_idx_w    = IMEM_AW + 1;
  localparam logic [c_idx_w-1:0]     c_idx_one  = c_idx_w'(1);
  localparam logic [c_idx_w-1:0]     c_last_idx = c_idx_w'(IMEM_DEPTH - 1);
  localparam logic [c_hdr_n_w-1:0]   c_depth_n  = c_hdr_n_w'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0]       c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0]       c_cnt_max  = '1;
  localparam logic [CNT_W-1:0]       c_run_last = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]       c_run_end  = CNT_W'(RUN_CYCLES);

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   r_len;

  logic                 r_ready;
  logic                 r_imem_we;
  logic [IMEM_AW-1:0]   r_imem_addr;
  logic [31:0]          r_imem_wdata;
  logic                 r_dmem_we;
  logic [31:0]          r_dmem_wdata;
  logic                 r_cpu_rst;
  logic                 r_cpu_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cycle;

  logic                 w_xfer;
  logic [c_hdr_n_w-1:0] w_hdr_n;

  assign w_xfer  = s_valid_i & r_ready;
  assign w_hdr_n = hdr_len(s_data_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_CLEAR;
      r_idx        <= '0;
      r_len        <= '0;
      r_ready      <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_wdata <= '0;
      r_cpu_rst    <= 1'b0;
      r_cpu_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cycle      <= '0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      unique case (r_state)
        S_CLEAR: begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= r_idx[IMEM_AW-1:0];
          r_imem_wdata <= '0;
          r_busy       <= 1'b1;
          r_ready      <= 1'b0;
          if (r_idx == c_last_idx) begin
            r_idx   <= '0;
            r_state <= S_HDR;
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end

        // Ready rises one cycle into HDR, so the first header can land no
        // earlier than the cycle after that.
        S_HDR: begin
          r_busy  <= 1'b1;
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_idx <= '0;
            if (w_hdr_n > c_depth_n) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
            end else if (w_hdr_n == '0) begin
              r_state <= S_DATA;
            end else begin
              r_len   <= c_idx_w'(w_hdr_n);
              r_state <= S_INSTR;
            end
          end
        end

        S_INSTR: begin
          if (w_xfer) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_idx[IMEM_AW-1:0];
            r_imem_wdata <= s_data_i;
            r_idx        <= r_idx + c_idx_one;
            if (r_idx + c_idx_one == r_len) begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_dmem_we    <= 1'b1;
            r_dmem_wdata <= s_data_i;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_cpu_start  <= 1'b1;
            r_cycle      <= '0;
            r_state      <= S_RUN;
          end
        end

        S_RUN: begin
          if (r_cycle == c_run_last) begin
            r_state     <= S_DONE;
            r_cpu_start <= 1'b0;
            r_done      <= 1'b1;
            r_cycle     <= c_run_end;
          end else if (r_cycle != c_cnt_max) begin
            r_cycle <= r_cycle + c_cnt_one;
          end
        end

        S_DONE, S_ERR: begin
          r_ready <= 1'b0;
        end

        default: begin
          r_state     <= S_ERR;
          r_err       <= 1'b1;
          r_ready     <= 1'b0;
          r_busy      <= 1'b0;
          r_cpu_rst   <= 1'b0;
          r_cpu_start <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready_o    = r_ready;
  assign imem_we_o    = r_imem_we;
  assign imem_addr_o  = r_imem_addr;
  assign imem_wdata_o = r_imem_wdata;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_wdata_o = r_dmem_wdata;
  assign cpu_rst_o    = r_cpu_rst;
  assign cpu_start_o  = r_cpu_start;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign cycle_o      = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_program_loader : randomized stimulus against a behavioural model  |
// |                     of the loader.                  Rev 1.0          |
// +----------------------------------------------------------------------+
module tb_program_loader;

  localparam int DEPTH = 256;
  localparam int RUN   = 30;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i     = 1'b1;
  logic        s_valid_i = 1'b0;
  logic [31:0] s_data_i  = '0;
  logic        s_ready_o, imem_we_o, dmem_we_o, cpu_rst_o, cpu_start_o;
  logic        busy_o, done_o, err_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_wdata_o, dmem_wdata_o;
  logic [15:0] cycle_o;

  program_loader #(
    .IMEM_DEPTH(DEPTH), .IMEM_AW(8), .RUN_CYCLES(RUN), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_wdata_o(imem_wdata_o), .dmem_we_o(dmem_we_o), .dmem_wdata_o(dmem_wdata_o),
    .cpu_rst_o(cpu_rst_o), .cpu_start_o(cpu_start_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .cycle_o(cycle_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each registered output must be after every edge.
  bit          m_live = 1'b0;
  int          m_clr, m_left, m_widx;
  bit          m_rdy_seen, m_hdr, m_run, m_err;
  logic        e_ready, e_imem_we, e_dmem_we, e_cpu_rst, e_start, e_busy, e_done, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_dwdata;
  int          e_cycle;

  always @(posedge clk) begin
    e_imem_we = 1'b0;
    e_dmem_we = 1'b0;
    if (rst_i) begin
      m_live = 1'b1; m_clr = 0; m_left = 0; m_widx = 0;
      m_rdy_seen = 1'b0; m_hdr = 1'b0; m_run = 1'b0; m_err = 1'b0;
      e_ready = 1'b0; e_cpu_rst = 1'b0; e_start = 1'b0; e_busy = 1'b0;
      e_done = 1'b0; e_err = 1'b0; e_cycle = 0;
    end else if (!m_live || m_err || e_done) begin
      // terminal or not yet reset: outputs hold
    end else if (m_clr < DEPTH) begin
      e_imem_we = 1'b1; e_addr = 8'(m_clr); e_wdata = '0; e_busy = 1'b1;
      m_clr++;
    end else if (!m_rdy_seen) begin
      m_rdy_seen = 1'b1; e_ready = 1'b1;
    end else if (m_run) begin
      if (e_cycle == RUN - 1) begin
        e_done = 1'b1; e_start = 1'b0; e_cycle = RUN; m_run = 1'b0;
      end else begin
        e_cycle++;
      end
    end else if (s_valid_i && e_ready) begin
      if (!m_hdr) begin
        m_hdr = 1'b1; m_widx = 0; m_left = int'(s_data_i[15:0]);
        if (m_left > DEPTH) begin
          m_err = 1'b1; e_err = 1'b1; e_ready = 1'b0; e_busy = 1'b0;
        end
      end else if (m_left > 0) begin
        e_imem_we = 1'b1; e_addr = 8'(m_widx); e_wdata = s_data_i;
        m_widx++; m_left--;
      end else begin
        e_dmem_we = 1'b1; e_dwdata = s_data_i; e_ready = 1'b0; e_busy = 1'b0;
        m_run = 1'b1; e_cpu_rst = 1'b1; e_start = 1'b1; e_cycle = 0;
      end
    end
  end

  // Observed side effects, rebuilt from the DUT's write ports.
  logic [31:0] shadow [DEPTH];
  int          clr_wr, ld_wr, clr_last, ld_last, dm_cnt, start_cnt;
  logic [31:0] dm_val;

  always @(negedge clk) begin
    if (rst_i) begin
      clr_wr = 0; ld_wr = 0; clr_last = -1; ld_last = -1; dm_cnt = 0; start_cnt = 0;
      dm_val = '0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hdead_beef;
    end
    if (m_live) begin
      chk("s_ready", 32'(s_ready_o), 32'(e_ready));
      chk("imem_we", 32'(imem_we_o), 32'(e_imem_we));
      chk("dmem_we", 32'(dmem_we_o), 32'(e_dmem_we));
      chk("cpu_rst", 32'(cpu_rst_o), 32'(e_cpu_rst));
      chk("cpu_start", 32'(cpu_start_o), 32'(e_start));
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("done", 32'(done_o), 32'(e_done));
      chk("err", 32'(err_o), 32'(e_err));
      chk("cycle", 32'(cycle_o), 32'(e_cycle));
      if (e_imem_we) begin
        chk("imem_addr", 32'(imem_addr_o), 32'(e_addr));
        chk("imem_wdata", imem_wdata_o, e_wdata);
      end
      if (e_dmem_we) chk("dmem_wdata", dmem_wdata_o, e_dwdata);
      if (!rst_i) begin
        if (imem_we_o === 1'b1) begin
          shadow[imem_addr_o] = imem_wdata_o;
          if (s_ready_o) begin ld_wr++; ld_last = int'(imem_addr_o); end
          else begin clr_wr++; clr_last = int'(imem_addr_o); end
        end
        if (dmem_we_o === 1'b1) begin dm_cnt++; dm_val = dmem_wdata_o; end
        if (cpu_start_o === 1'b1) start_cnt++;
      end
    end
  end

  logic [31:0] img [DEPTH];
  bit          tog = 1'b0;

  task automatic idle();
    @(negedge clk);
    s_valid_i = 1'b0;
    s_data_i  = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_i = 1'b1; s_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_i = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid toggles, 2: random gaps
  task automatic send(input logic [31:0] w, input int mode);
    int waited;
    bit sent, gap;
    waited = 0; sent = 1'b0;
    while (!sent) begin
      @(negedge clk);
      tog = ~tog;
      gap = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      s_valid_i = !gap;
      s_data_i  = gap ? $urandom : w;
      sent = s_valid_i && s_ready_o;
      waited++;
      if (!sent && waited > 2000) begin
        chk("send_timeout", 32'(s_ready_o), 32'd1);
        sent = 1'b1;
      end
    end
  endtask

  task automatic load_prog(input int n, input int mode, input logic [31:0] dval);
    send({16'($urandom_range(0, 65535)), 16'(n)}, mode);
    for (int i = 0; i < n; i++) send(img[i], mode);
    send(dval, mode);
    idle();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  task automatic check_image(input string nm, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (shadow[i] !== ((i < n) ? img[i] : 32'h0)) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    int k, n, nz;
    logic [31:0] dv;

    // Clear with valid held low
    rst_i = 1'b1; s_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    k = 0;
    while (s_ready_o !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    chk("ready_rise_cycle", 32'(k), 32'(DEPTH + 1));
    chk("clear_write_count", 32'(clr_wr), 32'd256);
    chk("clear_last_addr", 32'(clr_last), 32'd255);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (shadow[i] !== 32'h0) nz++;
    chk("clear_nonzero_words", 32'(nz), 32'd0);

    // Normal load: 3 words then input 5
    img[0] = 32'h1111_aaaa; img[1] = 32'h2222_bbbb; img[2] = 32'h3333_cccc;
    load_prog(3, 0, 32'd5);
    wait_done();
    chk("norm_imem0", shadow[0], 32'h1111_aaaa);
    chk("norm_imem1", shadow[1], 32'h2222_bbbb);
    chk("norm_imem2", shadow[2], 32'h3333_cccc);
    chk("norm_imem3", shadow[3], 32'h0);
    chk("norm_instr_writes", 32'(ld_wr), 32'd3);
    chk("norm_dmem_count", 32'(dm_cnt), 32'd1);
    chk("norm_dmem_value", dm_val, 32'd5);
    chk("norm_start_cycles", 32'(start_cnt), 32'd30);
    repeat (4) idle();
    chk("norm_cycle_final", 32'(cycle_o), 32'd30);
    chk("norm_done_sticky", 32'(done_o), 32'd1);
    chk("norm_cpu_rst_held", 32'(cpu_rst_o), 32'd1);

    // Valid toggling every other cycle
    do_reset();
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    load_prog(4, 1, 32'h0000_0042);
    wait_done();
    check_image("toggle_image", 4);
    chk("toggle_instr_writes", 32'(ld_wr), 32'd4);
    chk("toggle_dmem_count", 32'(dm_cnt), 32'd1);

    // Random length, random gaps
    for (int r = 0; r < 2; r++) begin
      do_reset();
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      dv = $urandom;
      load_prog(n, 2, dv);
      wait_done();
      check_image("rand_image", n);
      chk("rand_instr_writes", 32'(ld_wr), 32'(n));
      chk("rand_dmem_value", dm_val, dv);
    end

    // Header 0: straight to DATA
    do_reset();
    load_prog(0, 2, 32'h77);
    wait_done();
    chk("hdr0_instr_writes", 32'(ld_wr), 32'd0);
    chk("hdr0_dmem_value", dm_val, 32'h77);
    chk("hdr0_start_cycles", 32'(start_cnt), 32'd30);

    // Header 256: fills memory exactly
    do_reset();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    load_prog(256, 0, 32'h9);
    wait_done();
    check_image("full_image", 256);
    chk("full_instr_writes", 32'(ld_wr), 32'd256);
    chk("full_last_addr", 32'(ld_last), 32'd255);

    // Header 257: error, loader stops accepting
    do_reset();
    send(32'd257, 0);
    repeat (6) begin @(negedge clk); s_valid_i = 1'b1; s_data_i = $urandom; end
    chk("err_flag", 32'(err_o), 32'd1);
    chk("err_ready_low", 32'(s_ready_o), 32'd0);
    chk("err_cpu_in_reset", 32'(cpu_rst_o), 32'd0);
    chk("err_no_writes", 32'(ld_wr + dm_cnt), 32'd0);
    idle();

    // Reset during INSTR after 2 words
    do_reset();
    img[0] = $urandom; img[1] = $urandom;
    send(32'd5, 0); send(img[0], 0); send(img[1], 0);
    @(negedge clk); rst_i = 1'b1; s_valid_i = 1'b0;
    @(negedge clk);
    chk("midinstr_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("midinstr_cpu_start", 32'(cpu_start_o), 32'd0);
    chk("midinstr_imem_we", 32'(imem_we_o), 32'd0);
    @(negedge clk); rst_i = 1'b0;
    @(negedge clk);
    chk("midinstr_reclear_addr0", {23'd0, imem_we_o, imem_addr_o}, 32'h100);
    img[0] = 32'hcafe_0001; img[1] = 32'hcafe_0002;
    load_prog(2, 2, 32'h3);
    wait_done();
    check_image("midinstr_reload_image", 2);

    // Reset during RUN at cycle 10
    do_reset();
    img[0] = $urandom;
    load_prog(1, 0, 32'h1);
    k = 0;
    while (cycle_o !== 16'd10 && k < 100) begin @(negedge clk); k++; end
    chk("run_cycle10_seen", 32'(cycle_o), 32'd10);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrun_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("midrun_cpu_start", 32'(cpu_start_o), 32'd0);
    chk("midrun_cycle", 32'(cycle_o), 32'd0);
    @(negedge clk); rst_i = 1'b0;
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    load_prog(3, 0, 32'h2);
    wait_done();
    check_image("midrun_reload_image", 3);
    chk("midrun_reload_cycle", 32'(cycle_o), 32'd30);

    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
